// File: rtl/llc_out_queues.sv
// Per-channel output FIFOs between the LLC pipeline and the NoC/memory valid-ready channels.
// Optional macro LLC_OUT_BYPASS_EN: an empty FIFO with its consumer ready passes a push straight through.
package llc_out_pkg;
  typedef struct packed {
    logic [2:0]  coh_msg;
    logic [31:0] addr;
    logic [63:0] line;
    logic [3:0]  req_id;
  } llc_rsp_out_t;

  typedef struct packed {
    logic [2:0]  coh_msg;
    logic [31:0] addr;
    logic [3:0]  req_id;
    logic [3:0]  dest_id;
  } llc_fwd_out_t;

  typedef struct packed {
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] addr;
    logic [63:0] line;
  } llc_mem_req_t;
endpackage

module llc_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          stored_valid, push_fire, pop_fire;

  assign stored_valid = (count_reg != '0);
  assign push_ready   = (count_reg != CW'(DEPTH));
  assign empty        = !stored_valid;
  assign pop_fire     = stored_valid && out_ready;

`ifdef LLC_OUT_BYPASS_EN
  logic bypass;
  assign bypass    = push_valid && !stored_valid && out_ready;
  assign push_fire = push_valid && push_ready && !bypass;
  assign out_valid = stored_valid || push_valid;
  assign out_data  = stored_valid ? mem[rd_ptr_reg] : (push_valid ? push_data : '0);
`else
  assign push_fire = push_valid && push_ready;
  assign out_valid = stored_valid;
  // Mask the unreset storage so the head reads zero whenever the queue is empty.
  assign out_data  = stored_valid ? mem[rd_ptr_reg] : '0;
`endif

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_fire && !pop_fire)      count_reg <= count_reg + 1'b1;
      else if (pop_fire && !push_fire) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

module llc_out_queues
  import llc_out_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   push_valid,
  output logic [3:0]   push_ready,
  input  llc_rsp_out_t rsp_push_data,
  input  llc_rsp_out_t dma_rsp_push_data,
  input  llc_fwd_out_t fwd_push_data,
  input  llc_mem_req_t mem_req_push_data,
  input  logic         llc_rsp_out_ready,
  output logic         llc_rsp_out_valid,
  output llc_rsp_out_t llc_rsp_out,
  input  logic         llc_dma_rsp_out_ready,
  output logic         llc_dma_rsp_out_valid,
  output llc_rsp_out_t llc_dma_rsp_out,
  input  logic         llc_fwd_out_ready,
  output logic         llc_fwd_out_valid,
  output llc_fwd_out_t llc_fwd_out,
  input  logic         llc_mem_req_ready,
  output logic         llc_mem_req_valid,
  output llc_mem_req_t llc_mem_req,
  output logic         idle
);
  logic [3:0] empty;

  llc_out_fifo #(.DEPTH(DEPTH), .W($bits(llc_rsp_out_t))) u_rsp (
    .clk(clk), .rst(rst),
    .push_valid(push_valid[0]), .push_ready(push_ready[0]), .push_data(rsp_push_data),
    .out_ready(llc_rsp_out_ready), .out_valid(llc_rsp_out_valid), .out_data(llc_rsp_out),
    .empty(empty[0])
  );

  llc_out_fifo #(.DEPTH(DEPTH), .W($bits(llc_rsp_out_t))) u_dma_rsp (
    .clk(clk), .rst(rst),
    .push_valid(push_valid[1]), .push_ready(push_ready[1]), .push_data(dma_rsp_push_data),
    .out_ready(llc_dma_rsp_out_ready), .out_valid(llc_dma_rsp_out_valid), .out_data(llc_dma_rsp_out),
    .empty(empty[1])
  );

  llc_out_fifo #(.DEPTH(DEPTH), .W($bits(llc_fwd_out_t))) u_fwd (
    .clk(clk), .rst(rst),
    .push_valid(push_valid[2]), .push_ready(push_ready[2]), .push_data(fwd_push_data),
    .out_ready(llc_fwd_out_ready), .out_valid(llc_fwd_out_valid), .out_data(llc_fwd_out),
    .empty(empty[2])
  );

  llc_out_fifo #(.DEPTH(DEPTH), .W($bits(llc_mem_req_t))) u_mem_req (
    .clk(clk), .rst(rst),
    .push_valid(push_valid[3]), .push_ready(push_ready[3]), .push_data(mem_req_push_data),
    .out_ready(llc_mem_req_ready), .out_valid(llc_mem_req_valid), .out_data(llc_mem_req),
    .empty(empty[3])
  );

  assign idle = &empty;
endmodule

// File: tb/tb_llc_out_queues.sv
// Directed self-checking bench for llc_out_queues at DEPTH=2.
module tb_llc_out_queues;
  import llc_out_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   push_valid = '0;
  logic [3:0]   push_ready;
  llc_rsp_out_t rsp_push_data = '0, dma_rsp_push_data = '0;
  llc_fwd_out_t fwd_push_data = '0;
  llc_mem_req_t mem_req_push_data = '0;
  logic         llc_rsp_out_ready = 1'b1, llc_dma_rsp_out_ready = 1'b1;
  logic         llc_fwd_out_ready = 1'b1, llc_mem_req_ready = 1'b1;
  logic         llc_rsp_out_valid, llc_dma_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid;
  llc_rsp_out_t llc_rsp_out, llc_dma_rsp_out;
  llc_fwd_out_t llc_fwd_out;
  llc_mem_req_t llc_mem_req;
  logic         idle;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  llc_out_queues #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .rsp_push_data(rsp_push_data), .dma_rsp_push_data(dma_rsp_push_data),
    .fwd_push_data(fwd_push_data), .mem_req_push_data(mem_req_push_data),
    .llc_rsp_out_ready(llc_rsp_out_ready), .llc_rsp_out_valid(llc_rsp_out_valid), .llc_rsp_out(llc_rsp_out),
    .llc_dma_rsp_out_ready(llc_dma_rsp_out_ready), .llc_dma_rsp_out_valid(llc_dma_rsp_out_valid),
    .llc_dma_rsp_out(llc_dma_rsp_out),
    .llc_fwd_out_ready(llc_fwd_out_ready), .llc_fwd_out_valid(llc_fwd_out_valid), .llc_fwd_out(llc_fwd_out),
    .llc_mem_req_ready(llc_mem_req_ready), .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req(llc_mem_req),
    .idle(idle)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valids", {llc_rsp_out_valid, llc_dma_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid}, 4'h0);
    check("rst_push_ready", push_ready, 4'hF);
    check("rst_idle", idle, 1'b1);
    check("rst_rsp_data", llc_rsp_out, 64'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Single rsp push, req_id 5
    rsp_push_data = '0;
    rsp_push_data.req_id = 4'd5;
    push_valid = 4'b0001;
`ifdef LLC_OUT_BYPASS_EN
    #1;
    check("byp_rsp_valid_same", llc_rsp_out_valid, 1'b1);
    check("byp_rsp_id_same", llc_rsp_out.req_id, 4'd5);
    tick();
    push_valid = '0;
    #1;
    check("byp_rsp_empty", llc_rsp_out_valid, 1'b0);
    check("byp_idle", idle, 1'b1);
`else
    #1;
    check("rsp_valid_before", llc_rsp_out_valid, 1'b0);
    tick();
    push_valid = '0;
    check("rsp_valid", llc_rsp_out_valid, 1'b1);
    check("rsp_id", llc_rsp_out.req_id, 4'd5);
    check("idle_busy", idle, 1'b0);
    tick();
    check("rsp_empty", llc_rsp_out_valid, 1'b0);
    check("idle_after", idle, 1'b1);
`endif

    // fwd back-pressure fill and ordered drain
    llc_fwd_out_ready = 1'b0;
    fwd_push_data = '0;
    fwd_push_data.req_id = 4'd1;
    push_valid = 4'b0100;
    tick();
    fwd_push_data.req_id = 4'd2;
    tick();
    check("fwd_full_ready", push_ready[2], 1'b0);
    fwd_push_data.req_id = 4'd3;
    tick();
    check("fwd_held_ready", push_ready[2], 1'b0);
    check("fwd_head1", llc_fwd_out.req_id, 4'd1);
    llc_fwd_out_ready = 1'b1;
    tick();
    check("fwd_head2", llc_fwd_out.req_id, 4'd2);
    check("fwd_ready_again", push_ready[2], 1'b1);
    tick();
    push_valid = '0;
    check("fwd_head3", llc_fwd_out.req_id, 4'd3);
    tick();
    check("fwd_drained", llc_fwd_out_valid, 1'b0);

    // mem_req full with simultaneous pop and push
    llc_mem_req_ready = 1'b0;
    mem_req_push_data = '0;
    mem_req_push_data.addr = 32'hA;
    push_valid = 4'b1000;
    tick();
    mem_req_push_data.addr = 32'hB;
    tick();
    mem_req_push_data.addr = 32'hC;
    llc_mem_req_ready = 1'b1;
    check("mem_full_ready", push_ready[3], 1'b0);
    check("mem_headA", llc_mem_req.addr, 32'hA);
    tick();
    check("mem_headB", llc_mem_req.addr, 32'hB);
    check("mem_ready_after_pop", push_ready[3], 1'b1);
    tick();
    push_valid = '0;
    check("mem_headC", llc_mem_req.addr, 32'hC);
    tick();
    check("mem_drained", llc_mem_req_valid, 1'b0);

    // Independent channels: rsp drains, dma_rsp holds
    llc_dma_rsp_out_ready = 1'b0;
    rsp_push_data = '0;
    rsp_push_data.req_id = 4'd7;
    dma_rsp_push_data = '0;
    dma_rsp_push_data.req_id = 4'd8;
    push_valid = 4'b0011;
    tick();
    push_valid = '0;
    check("dma_valid", llc_dma_rsp_out_valid, 1'b1);
    check("dma_id", llc_dma_rsp_out.req_id, 4'd8);
`ifndef LLC_OUT_BYPASS_EN
    check("rsp7_id", llc_rsp_out.req_id, 4'd7);
`endif
    tick();
    check("rsp_drained", llc_rsp_out_valid, 1'b0);
    check("dma_holds", llc_dma_rsp_out_valid, 1'b1);
    check("idle_dma_pending", idle, 1'b0);
    llc_dma_rsp_out_ready = 1'b1;
    tick();
    check("dma_drained", llc_dma_rsp_out_valid, 1'b0);
    check("idle_all", idle, 1'b1);

    // Async reset with every queue full
    {llc_rsp_out_ready, llc_dma_rsp_out_ready, llc_fwd_out_ready, llc_mem_req_ready} = 4'h0;
    rsp_push_data.req_id = 4'd9;
    dma_rsp_push_data.req_id = 4'd10;
    fwd_push_data.req_id = 4'd11;
    mem_req_push_data.addr = 32'h55;
    push_valid = 4'hF;
    repeat (2) tick();
    push_valid = '0;
    check("full_push_ready", push_ready, 4'h0);
    check("full_valids", {llc_rsp_out_valid, llc_dma_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid}, 4'hF);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valids", {llc_rsp_out_valid, llc_dma_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid}, 4'h0);
    check("arst_push_ready", push_ready, 4'hF);
    check("arst_idle", idle, 1'b1);
    check("arst_mem_data", llc_mem_req.addr, 32'h0);
    tick();
    rst = 1'b1;
    {llc_rsp_out_ready, llc_dma_rsp_out_ready, llc_fwd_out_ready, llc_mem_req_ready} = 4'hF;
    repeat (2) tick();
    check("post_rst_valids", {llc_rsp_out_valid, llc_dma_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid}, 4'h0);
    check("post_rst_idle", idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/llc_out_queues.md
# llc_out_queues

Output buffering stage directly downstream of the LLC processing pipeline. It accepts the messages the LLC produces on four internal push channels (coherence response, DMA response, forward, memory request) and holds each in an independent FIFO. Each FIFO drives the matching external valid/ready output channel. The LLC can therefore post messages during PROCESS without waiting on NoC or memory back-pressure.

## Interface
Parameters:
- DEPTH, 2, entries per channel FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- push_valid  in  4  per-channel push request; bit 0 rsp, 1 dma_rsp, 2 fwd, 3 mem_req.
- push_ready  out  4  per-channel "FIFO not full".
- rsp_push_data  in  llc_rsp_out_t  coherence response payload.
- dma_rsp_push_data  in  llc_rsp_out_t  DMA response payload.
- fwd_push_data  in  llc_fwd_out_t  forward payload.
- mem_req_push_data  in  llc_mem_req_t  memory request payload.
- llc_rsp_out_ready  in  1  downstream ready, rsp.
- llc_rsp_out_valid  out  1  rsp head valid.
- llc_rsp_out  out  llc_rsp_out_t  rsp head.
- llc_dma_rsp_out_ready  in  1  downstream ready, dma_rsp.
- llc_dma_rsp_out_valid  out  1  dma_rsp head valid.
- llc_dma_rsp_out  out  llc_rsp_out_t  dma_rsp head.
- llc_fwd_out_ready  in  1  downstream ready, fwd.
- llc_fwd_out_valid  out  1  fwd head valid.
- llc_fwd_out  out  llc_fwd_out_t  fwd head.
- llc_mem_req_ready  in  1  downstream ready, mem_req.
- llc_mem_req_valid  out  1  mem_req head valid.
- llc_mem_req  out  llc_mem_req_t  mem_req head.
- idle  out  1  all four FIFOs empty.

## Operation
- Each channel has a circular FIFO with the following state:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Push fires when push_valid[i] && push_ready[i]: the entry is written at wr_ptr and wr_ptr increments.
- Pop fires when out_valid && out_ready: rd_ptr increments.
- count update: +1 on push only, −1 on pop only, unchanged when both fire in the same cycle.
- push_ready[i] = (count != DEPTH).
  - It is a function of registered state only.
  - It never depends on out_ready, so no combinational ready→ready path exists.
- When full, a push is refused even if a pop fires in the same cycle.
- A push on a refused cycle has no effect. The producer holds its data until push_ready is seen.
- out_valid = (count != 0). The out data is the entry at rd_ptr.
- Once out_valid is asserted, out_valid and the out data remain stable until the pop fires.
- Ordering is strict FIFO within a channel. There is no ordering between channels; each output advances independently.
- idle = all counts zero. The LLC uses idle to sequence reset/flush completion.

## Timing
- Reset (rst low, async): all pointers and counts are 0. Outputs:
  - all out_valid = 0;
  - push_ready = 4'b1111;
  - idle = 1;
  - out data = 0.
- Push-to-valid latency is 1 cycle: data pushed at edge N is visible with out_valid high after edge N.
- Sustained throughput is one push and one pop per channel per cycle at any count < DEPTH.
- A reset asserted mid-operation discards all queued entries immediately. No partial message is emitted after reset.
- Count boundaries:
  - count = DEPTH−1 with a push and no pop: full next cycle, push_ready drops.
  - count = 1 with a pop and no push: empty next cycle, out_valid drops, and idle rises if all other channels are empty.

## Configuration
- LLC_OUT_BYPASS_EN defined: a push to an empty FIFO whose out_ready is high passes through in the same cycle.
  - out_valid = push_valid and out data = push data, combinationally.
  - No entry is written and count stays 0.
  - If out_ready is low, the push is stored normally.
- LLC_OUT_BYPASS_EN undefined: there is no combinational push→out path, and latency is always 1 cycle.

## Test plan
- Reset then idle: out_valids 0, push_ready 4'hF, idle 1; after a rsp push, idle goes 0.
- Single rsp push of req_id 5 with llc_rsp_out_ready=1: out_valid high 1 cycle later with req_id 5, then empty.
  - With LLC_OUT_BYPASS_EN: out_valid in the same cycle and count stays 0.
- Back-pressure fill: fwd ready held 0; push 3 messages at DEPTH=2.
  - push_ready[2] drops after 2 pushes and the third is held.
  - Release ready: output order is 1, 2, 3.
- Full with simultaneous pop and push on mem_req: push refused that cycle and count goes 2→1; the push is accepted the next cycle.
- Independent channels: dma_rsp ready 0 while rsp ready 1; pushes on both.
  - rsp drains and dma_rsp holds.
  - idle rises only after the dma_rsp drain.
- Async reset with 2 entries queued in every channel: all valids drop before the next edge and no entry reappears after reset release.
